// File: rtl/iq_tx_deframer_pkg.sv
// rtl/iq_tx_deframer_pkg.sv - shared widths and state encodings for the TX I/Q deframer
package iq_tx_deframer_pkg;
  localparam int FRAME_W = 32;
  localparam int WORD_W  = 16;
  localparam int SLOTS   = 16;
  localparam int SLOT_W  = $clog2(SLOTS);

  typedef enum logic {EXPECT_FIRST, EXPECT_SECOND} asm_state_t;
  typedef enum logic {IDLE, RUN} ser_state_t;
endpackage

// File: rtl/iq_frame_serializer.sv
// rtl/iq_frame_serializer.sv - 32-bit frame to dibit serializer with slot counter and underrun count
module iq_frame_serializer
  import iq_tx_deframer_pkg::*;
#(
  parameter logic [FRAME_W-1:0] IDLE_FRAME = '0,
  parameter int                 CNT_W      = 8
) (
  input  logic               i_sys_clk,
  input  logic               i_rst_b,
  input  logic               i_tx_en,
  input  logic               i_staged_valid,
  input  logic [FRAME_W-1:0] i_staged,
  output logic               o_consume,
  output logic [1:0]         o_tx_dibit,
  output logic               o_frame_start,
  output logic               o_active,
  output logic [CNT_W-1:0]   o_underrun_cnt
);
  ser_state_t         r_state;
  logic [SLOT_W-1:0]  r_slot;
  logic [FRAME_W-1:0] r_sr;
  logic               r_frame_start;
  logic [CNT_W-1:0]   r_underrun;
  logic               w_boundary;

  assign w_boundary = (r_state == RUN) && (r_slot == SLOT_W'(SLOTS - 1));
  assign o_consume  = i_tx_en && i_staged_valid && ((r_state == IDLE) || w_boundary);

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state       <= IDLE;
      r_slot        <= '0;
      r_sr          <= '0;
      r_frame_start <= 1'b0;
      r_underrun    <= '0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_tx_en && i_staged_valid) begin
            r_state       <= RUN;
            r_slot        <= '0;
            r_sr          <= i_staged;
            r_frame_start <= 1'b1;
          end
        end
        RUN: begin
          if (!w_boundary) begin
            r_slot <= r_slot + SLOT_W'(1);
            r_sr   <= {r_sr[FRAME_W-3:0], 2'b00};
          end else if (!i_tx_en) begin
            // clearing the shift register keeps the idle dibit at 00
            r_state <= IDLE;
            r_slot  <= '0;
            r_sr    <= '0;
          end else begin
            r_slot        <= '0;
            r_frame_start <= 1'b1;
            if (i_staged_valid) begin
              r_sr <= i_staged;
            end else begin
              r_sr <= IDLE_FRAME;
              if (r_underrun != '1) r_underrun <= r_underrun + CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx_dibit     = r_sr[FRAME_W-1 -: 2];
  assign o_frame_start  = r_frame_start;
  assign o_active       = (r_state == RUN);
  assign o_underrun_cnt = r_underrun;
endmodule

// File: rtl/iq_tx_deframer.sv
// rtl/iq_tx_deframer.sv - pulls 16-bit words, pairs them on the bit-0 sync marker, feeds the serializer
module iq_tx_deframer
  import iq_tx_deframer_pkg::*;
#(
  parameter logic [FRAME_W-1:0] IDLE_FRAME = 32'h0000_0000,
  parameter int                 CNT_W      = 8
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_b,
  input  logic              i_tx_en,
  output logic              o_tx_fifo_pull,
  input  logic [WORD_W-1:0] i_tx_fifo_pulled_data,
  input  logic              i_tx_fifo_empty,
  output logic [1:0]        o_tx_dibit,
  output logic              o_frame_start,
  output logic              o_active,
  output logic [CNT_W-1:0]  o_underrun_cnt,
  output logic [CNT_W-1:0]  o_sync_err_cnt
);
  asm_state_t         r_asm_state;
  logic               r_pull_q;
  logic [WORD_W-1:0]  r_w0;
  logic [FRAME_W-1:0] r_staged;
  logic               r_staged_valid;
  logic [CNT_W-1:0]   r_sync_err;
  logic               w_consume;
  logic               w_sync_err;

  // at most one word in flight, and nothing fetched while a sample waits
  assign o_tx_fifo_pull = i_tx_en && !i_tx_fifo_empty && !r_staged_valid && !r_pull_q;
  assign w_sync_err     = r_pull_q && (i_tx_fifo_pulled_data[0] == (r_asm_state == EXPECT_SECOND));

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_asm_state    <= EXPECT_FIRST;
      r_pull_q       <= 1'b0;
      r_w0           <= '0;
      r_staged       <= '0;
      r_staged_valid <= 1'b0;
      r_sync_err     <= '0;
    end else begin
      r_pull_q <= o_tx_fifo_pull;
      if (r_pull_q) begin
        if (i_tx_fifo_pulled_data[0]) begin
          r_w0        <= i_tx_fifo_pulled_data;
          r_asm_state <= EXPECT_SECOND;
        end else if (r_asm_state == EXPECT_SECOND) begin
          r_staged       <= {r_w0, i_tx_fifo_pulled_data};
          r_staged_valid <= 1'b1;
          r_asm_state    <= EXPECT_FIRST;
        end
      end
      if (w_sync_err && (r_sync_err != '1)) r_sync_err <= r_sync_err + CNT_W'(1);
      if (w_consume) r_staged_valid <= 1'b0;
    end
  end

  iq_frame_serializer #(
    .IDLE_FRAME (IDLE_FRAME),
    .CNT_W      (CNT_W)
  ) u_serializer (
    .i_sys_clk      (i_sys_clk),
    .i_rst_b        (i_rst_b),
    .i_tx_en        (i_tx_en),
    .i_staged_valid (r_staged_valid),
    .i_staged       (r_staged),
    .o_consume      (w_consume),
    .o_tx_dibit     (o_tx_dibit),
    .o_frame_start  (o_frame_start),
    .o_active       (o_active),
    .o_underrun_cnt (o_underrun_cnt)
  );

  assign o_sync_err_cnt = r_sync_err;
endmodule
